// File: rtl/sh_sync_gen_if.sv
// Signal bundle between the RF front end / TX control and sh_sync_gen.
// master drives rfin/rx_mode/tx_rdy; slave (the generator) drives the strobes and status.
interface sh_sync_gen_if #(
    parameter int unsigned CNT_W = 16
);
    logic             rfin;
    logic             rx_mode;
    logic             tx_rdy;
    logic             sh_en;
    logic             fsm_rst;
    logic             timeout_err;
    logic             locked;
    logic             busy;
    logic [CNT_W-1:0] avg_period;

    modport master (
        output rfin, rx_mode, tx_rdy,
        input  sh_en, fsm_rst, timeout_err, locked, busy, avg_period
    );

    modport slave (
        input  rfin, rx_mode, tx_rdy,
        output sh_en, fsm_rst, timeout_err, locked, busy, avg_period
    );
endinterface

// File: rtl/sh_sync_gen.sv
// Sample-and-hold sync generator: learns the rfin period (RX) or bursts fixed-interval strobes (TX).
// Optional feature macro: SH_SYNC_GLITCH_FILTER_EN (rfin must stay high GLITCH_CYCLES cycles to count).
module sh_sync_gen #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned N_TRAIN       = 8,
    parameter int unsigned N_GEN         = 65,
    parameter int unsigned PHASE_SHIFT   = 1,
    parameter int unsigned TIMEOUT       = 20000,
    parameter int unsigned TX_INTERVAL   = 10000,
    parameter int unsigned N_TX          = 8,
    parameter int unsigned GLITCH_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    sh_sync_gen_if.slave bus
);

`ifdef SH_SYNC_GLITCH_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    // A qualification length of 1 degenerates to a plain rising-edge detect.
    localparam int unsigned QUAL    = FILTER_EN ? GLITCH_CYCLES : 1;
    localparam int unsigned QW      = $clog2(QUAL + 1);
    localparam int unsigned LOG_N   = $clog2(N_TRAIN);
    localparam int unsigned SUM_W   = CNT_W + LOG_N;
    localparam int unsigned ET_W    = $clog2(N_TRAIN + 2);
    localparam int unsigned GEN_MAX = (N_GEN > N_TX) ? N_GEN : N_TX;
    localparam int unsigned GC_W    = $clog2(GEN_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAIN,
        S_COMPUTE,
        S_GEN,
        S_TX_WAIT,
        S_TX_SEND
    } state_t;

    logic [1:0]       rf_sync;
    logic [QW-1:0]    hi_cnt;
    logic             edge_q;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] avg_q;
    logic [CNT_W-1:0] gen_target;
    logic [SUM_W-1:0] sum;
    logic [ET_W-1:0]  edge_cnt;
    logic [GC_W-1:0]  gen_cnt;
    logic             sh_en_q;
    logic             fsm_rst_q;
    logic             timeout_q;

    // rfin synchroniser and high-run qualifier; edge_q fires once per qualified high period
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_sync <= '0;
            hi_cnt  <= '0;
            edge_q  <= 1'b0;
        end else begin
            rf_sync <= {rf_sync[0], bus.rfin};
            if (!rf_sync[1]) begin
                hi_cnt <= '0;
            end else if (hi_cnt != QW'(QUAL)) begin
                hi_cnt <= hi_cnt + QW'(1);
            end
            edge_q <= rf_sync[1] && (hi_cnt == QW'(QUAL - 1));
        end
    end

    // First GEN strobe lands at the phase offset, later ones a full period apart.
    assign gen_target = (gen_cnt == '0) ? (avg_q >> PHASE_SHIFT) : (avg_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            avg_q     <= '0;
            sum       <= '0;
            edge_cnt  <= '0;
            gen_cnt   <= '0;
            sh_en_q   <= 1'b0;
            fsm_rst_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sh_en_q   <= 1'b0;
            fsm_rst_q <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    cnt      <= '0;
                    sum      <= '0;
                    edge_cnt <= '0;
                    gen_cnt  <= '0;
                    if (!bus.rx_mode) begin
                        state <= S_TX_WAIT;
                    end else if (edge_q) begin
                        state    <= S_TRAIN;
                        edge_cnt <= ET_W'(1);
                    end
                end
                S_TRAIN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!bus.rx_mode) begin
                        state <= S_IDLE;
                    end else if (edge_q) begin
                        sum       <= sum + SUM_W'(cnt) + SUM_W'(1);
                        cnt       <= '0;
                        edge_cnt  <= edge_cnt + ET_W'(1);
                        fsm_rst_q <= 1'b1;
                        if (edge_cnt == ET_W'(N_TRAIN)) begin
                            state <= S_COMPUTE;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        fsm_rst_q <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_COMPUTE: begin
                    avg_q   <= CNT_W'(sum >> LOG_N);
                    cnt     <= '0;
                    gen_cnt <= '0;
                    state   <= S_GEN;
                end
                S_GEN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!bus.rx_mode) begin
                        state <= S_IDLE;
                    end else if (cnt == gen_target) begin
                        sh_en_q <= 1'b1;
                        cnt     <= '0;
                        gen_cnt <= gen_cnt + GC_W'(1);
                        if (gen_cnt == GC_W'(N_GEN - 1)) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_TX_WAIT: begin
                    cnt <= '0;
                    if (bus.rx_mode) begin
                        state <= S_IDLE;
                    end else if (bus.tx_rdy) begin
                        gen_cnt <= '0;
                        state   <= S_TX_SEND;
                    end
                end
                S_TX_SEND: begin
                    cnt <= cnt + CNT_W'(1);
                    if (bus.rx_mode) begin
                        state <= S_IDLE;
                    end else if (cnt == CNT_W'(TX_INTERVAL - 1)) begin
                        sh_en_q <= 1'b1;
                        cnt     <= '0;
                        gen_cnt <= gen_cnt + GC_W'(1);
                        if (gen_cnt == GC_W'(N_TX - 1)) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.sh_en       = sh_en_q;
    assign bus.fsm_rst     = fsm_rst_q;
    assign bus.timeout_err = timeout_q;
    assign bus.avg_period  = avg_q;
    assign bus.locked      = (state == S_GEN);
    assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_sh_sync_gen.sv
// Bench for sh_sync_gen: per-cycle input schedule plus an expected-output timeline derived
// from rfin edge times and the period/strobe arithmetic; checked every cycle.
module tb_sh_sync_gen;

    localparam int unsigned CNT_W         = 16;
    localparam int unsigned N_TRAIN       = 4;
    localparam int unsigned N_GEN         = 5;
    localparam int unsigned PHASE_SHIFT   = 1;
    localparam int unsigned TIMEOUT       = 200;
    localparam int unsigned TX_INTERVAL   = 20;
    localparam int unsigned N_TX          = 3;
    localparam int unsigned GLITCH_CYCLES = 4;
    localparam int          MAXC          = 4000;

`ifdef SH_SYNC_GLITCH_FILTER_EN
    localparam int LAT    = 2 + GLITCH_CYCLES;
    localparam int MIN_W  = GLITCH_CYCLES;
    localparam int GL_AVG = 50;
`else
    localparam int LAT    = 3;
    localparam int MIN_W  = 1;
    localparam int GL_AVG = 37;
`endif
    localparam int PW = (MIN_W >= 3) ? MIN_W + 1 : 3;

    logic clk = 1'b0;
    logic rst;

    sh_sync_gen_if #(.CNT_W(CNT_W)) bus ();

    sh_sync_gen #(
        .CNT_W(CNT_W), .N_TRAIN(N_TRAIN), .N_GEN(N_GEN), .PHASE_SHIFT(PHASE_SHIFT),
        .TIMEOUT(TIMEOUT), .TX_INTERVAL(TX_INTERVAL), .N_TX(N_TX), .GLITCH_CYCLES(GLITCH_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    bit s_rst[MAXC], s_rf[MAXC], s_rx[MAXC], s_tx[MAXC];
    bit e_sh[MAXC], e_fr[MAXC], e_to[MAXC], e_busy[MAXC], e_lock[MAXC];
    int e_avg[MAXC];

    int cyc = 0;
    int n_checks = 0, n_fail = 0;
    int n_sh = 0, n_fr = 0, n_to = 0;
    int pin_t1, pin_2c, pin_gl, pin_to, end_c;

    task automatic check(input string name, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic set_busy(input int a, input int b);
        for (int c = a; c <= b; c++) e_busy[c] = 1'b1;
    endtask

    task automatic set_lock(input int a, input int b);
        for (int c = a; c <= b; c++) e_lock[c] = 1'b1;
    endtask

    task automatic set_avg(input int from, input int v);
        for (int c = from; c < MAXC; c++) e_avg[c] = v;
    endtask

    task automatic clear_from(input int from);
        for (int c = from; c < MAXC; c++) begin
            e_sh[c] = 0; e_fr[c] = 0; e_to[c] = 0; e_busy[c] = 0; e_lock[c] = 0; e_avg[c] = 0;
        end
    endtask

    task automatic pulse(input int k, input int w);
        for (int c = k; c < k + w; c++) s_rf[c] = 1'b1;
    endtask

    // An edge is acted on LAT+1 cycles after rfin rises; the period is the mean spacing of
    // the first N_TRAIN+1 qualifying edges; strobes show one cycle after the counter hits.
    task automatic plan_rx(input int rise[6], input int wid[6], input int n, output int done);
        int p[$];
        int a, g, s0;
        for (int i = 0; i < n; i++) begin
            pulse(rise[i], wid[i]);
            if (wid[i] >= MIN_W) p.push_back(rise[i] + LAT + 1);
        end
        for (int j = 1; j <= int'(N_TRAIN); j++) e_fr[p[j]] = 1'b1;
        a    = (p[N_TRAIN] - p[0]) / int'(N_TRAIN);
        g    = p[N_TRAIN] + 1;
        s0   = g + a / (2 ** PHASE_SHIFT) + 1;
        for (int i = 0; i < int'(N_GEN); i++) e_sh[s0 + i * a] = 1'b1;
        done = s0 + (int'(N_GEN) - 1) * a;
        set_busy(p[0], done - 1);
        set_lock(g, done - 1);
        set_avg(g, a);
    endtask

    task automatic plan_timeout(input int k0, output int done);
        int p0, p1;
        pulse(k0, PW);
        pulse(k0 + 50, PW);
        p0 = k0 + LAT + 1;
        p1 = p0 + 50;
        e_fr[p1] = 1'b1;
        e_fr[p1 + int'(TIMEOUT)] = 1'b1;
        e_to[p1 + int'(TIMEOUT)] = 1'b1;
        set_busy(p0, p1 + int'(TIMEOUT) - 1);
        done = p1 + int'(TIMEOUT);
    endtask

    // One compare process: every cycle after the first edge, plus literal pins at milestones.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (bus.sh_en === 1'b1) n_sh++;
            if (bus.fsm_rst === 1'b1) n_fr++;
            if (bus.timeout_err === 1'b1) n_to++;
            check("sh_en", 32'(bus.sh_en), int'(e_sh[cyc]));
            check("fsm_rst", 32'(bus.fsm_rst), int'(e_fr[cyc]));
            check("timeout_err", 32'(bus.timeout_err), int'(e_to[cyc]));
            check("busy", 32'(bus.busy), int'(e_busy[cyc]));
            check("locked", 32'(bus.locked), int'(e_lock[cyc]));
            check("avg_period", 32'(bus.avg_period), e_avg[cyc]);
            if (cyc == pin_t1) begin
                check("t1_strobes", 32'(n_sh), 5);
                check("t1_fsm_rst", 32'(n_fr), 4);
                check("t1_avg", 32'(bus.avg_period), 50);
            end
            if (cyc == pin_2c) check("trunc_avg", 32'(bus.avg_period), 41);
            if (cyc == pin_gl) check("glitch_avg", 32'(bus.avg_period), GL_AVG);
            if (cyc == pin_to) begin
                check("timeout_pulses", 32'(n_to), 1);
                check("timeout_avg_held", 32'(bus.avg_period), GL_AVG);
            end
            if (cyc == end_c) begin
                check("total_strobes", 32'(n_sh), 32);
                check("total_fsm_rst", 32'(n_fr), 26);
                check("rst_avg", 32'(bus.avg_period), 0);
            end
        end
    end

    initial begin
        int d, t, t0, s, s2, x, r;
        for (int c = 0; c < 5; c++) s_rst[c] = 1'b1;
        for (int c = 0; c < MAXC; c++) s_rx[c] = 1'b1;

        plan_rx('{20, 70, 120, 170, 220, 0}, '{PW, PW, PW, PW, PW, 0}, 5, d);
        pin_t1 = d + 2;
        t = d + 30;
        plan_rx('{t, t + 48, t + 100, t + 149, t + 200, 0}, '{PW, PW, PW, PW, PW, 0}, 5, d);
        t = d + 30;
        plan_rx('{t, t + 50, t + 100, t + 150, t + 203, 0}, '{PW, PW, PW, PW, PW, 0}, 5, d);
        t = d + 30;
        plan_rx('{t, t + 40, t + 81, t + 123, t + 166, 0}, '{PW, PW, PW, PW, PW, 0}, 5, d);
        pin_2c = d + 2;
        t = d + 30;
        plan_rx('{t, t + 50, t + 75, t + 100, t + 150, t + 200}, '{PW, PW, 2, PW, PW, PW}, 6, d);
        pin_gl = d + 2;
        t = d + 30;
        plan_timeout(t, d);
        pin_to = d + 2;

        // TX burst, a second burst cut short by rx_mode coinciding with its second strobe
        t0 = d + 10;
        s_tx[t0 + 5] = 1'b1;
        s_tx[t0 + 6] = 1'b1;
        s = t0 + 6;
        for (int i = 1; i <= int'(N_TX); i++) e_sh[s + i * int'(TX_INTERVAL)] = 1'b1;
        s_tx[s + 70] = 1'b1;
        s2 = s + 71;
        e_sh[s2 + int'(TX_INTERVAL)] = 1'b1;
        x = s2 + 2 * int'(TX_INTERVAL) - 1;
        for (int c = t0; c < x; c++) s_rx[c] = 1'b0;
        set_busy(t0 + 1, s + 3 * int'(TX_INTERVAL) - 1);
        set_busy(s + 3 * int'(TX_INTERVAL) + 1, x);

        // reset in the middle of GEN
        t = x + 30;
        plan_rx('{t, t + 50, t + 100, t + 150, t + 200, 0}, '{PW, PW, PW, PW, PW, 0}, 5, d);
        r = d - 60;
        s_rst[r] = 1'b1;
        clear_from(r + 1);
        end_c = r + 30;

        rst         = s_rst[0];
        bus.rfin    = s_rf[0];
        bus.rx_mode = s_rx[0];
        bus.tx_rdy  = s_tx[0];
        for (int c = 1; c <= end_c; c++) begin
            @(posedge clk);
            cyc = c;
            #1;
            rst         = s_rst[c];
            bus.rfin    = s_rf[c];
            bus.rx_mode = s_rx[c];
            bus.tx_rdy  = s_tx[c];
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
